// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the scan-capture (read) and drive paths.
// Pattern bit0 = segment a ... bit6 = segment g, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // WAIT: current sample not yet committed; HOLD: committed, waiting for a change
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scanned seven-segment bus plus the reconstructed per-digit results.
// master = whoever drives the display lines, slave = the capture block.
interface seg_scan_capture_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                      common_anode;
  logic [6:0]                seg_in;
  logic [NUM_DIGITS-1:0]     dig_en;
  logic [4*NUM_DIGITS-1:0]   bcd_out;
  logic [NUM_DIGITS-1:0]     blank_out;
  logic [NUM_DIGITS-1:0]     err_out;
  logic                      digit_update;
  logic                      frame_valid;

  modport master (
    output common_anode, seg_in, dig_en,
    input  bcd_out, blank_out, err_out, digit_update, frame_valid
  );

  modport slave (
    input  common_anode, seg_in, dig_en,
    output bcd_out, blank_out, err_out, digit_update, frame_valid
  );

endinterface

// File: rtl/seg2bcd.sv
// Combinational decode of an active-high segment pattern into a BCD code,
// with separate flags for the all-off (blank) and unrecognised cases.
module seg2bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       blank,
  output logic       illegal
);

  // Match against the shared digit table; anything unlisted is illegal
  always_comb begin
    code    = BCD_ERR;
    blank   = 1'b0;
    illegal = 1'b0;
    case (seg_n)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code  = BCD_BLANK;
        blank = 1'b1;
      end
      default: begin
        code    = BCD_ERR;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs per-digit BCD values from a time-multiplexed seven-segment bus.
// Each registered sample must stay identical for STABLE_CYCLES samples before
// it is committed to the slot selected by the one-hot digit enable.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  seg_scan_capture_if.slave bus
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]              seg_d;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    changed;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  state_t                  state;
  state_t                  state_next;
  logic                    commit;
  logic                    valid_commit;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   seen_set;
  logic [3:0]              dec_code;
  logic                    dec_blank;
  logic                    dec_illegal;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   err_q;
  logic                    update_q;
  logic                    frame_q;

  // Polarity is folded in before the register, so flipping common_anode looks
  // like any other sample change and restarts the filter.
  assign seg_d   = bus.common_anode ? ~bus.seg_in : bus.seg_in;
  assign changed = (seg_d != seg_q) || (bus.dig_en != en_q);

  // Run-length counter: restart on change, otherwise count up and saturate
  always_comb begin
    cnt_next = cnt;
    if (changed)
      cnt_next = '0;
    else if (cnt != CNT_MAX)
      cnt_next = cnt + CNT_W'(1);
  end

  // Capture the normalised sample and advance the stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= '0;
      en_q  <= '0;
      cnt   <= '0;
    end else begin
      seg_q <= seg_d;
      en_q  <= bus.dig_en;
      cnt   <= cnt_next;
    end
  end

  // Commit once per stable run; a new sample always reopens the WAIT window
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      ST_WAIT: begin
        if (cnt == CNT_MAX) begin
          commit     = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: state_next = ST_HOLD;
      default: state_next = ST_WAIT;
    endcase
    if (changed)
      state_next = ST_WAIT;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_WAIT;
    else
      state <= state_next;
  end

  // Zero-hot or multi-hot enables consume the commit without touching outputs
  assign valid_commit = commit && $onehot(en_q);
  assign seen_set     = seen | en_q;

  seg2bcd u_seg2bcd (
    .seg_n   (seg_q),
    .code    (dec_code),
    .blank   (dec_blank),
    .illegal (dec_illegal)
  );

  // Slot registers, frame tracking and the one-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q    <= {NUM_DIGITS{BCD_BLANK}};
      blank_q  <= '1;
      err_q    <= '0;
      seen     <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      update_q <= valid_commit;
      frame_q  <= 1'b0;
      if (valid_commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (en_q[i]) begin
            bcd_q[4*i +: 4] <= dec_code;
            blank_q[i]      <= dec_blank;
            err_q[i]        <= dec_illegal;
          end
        end
        if (&seen_set) begin
          frame_q <= 1'b1;
          seen    <= '0;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

  assign bus.bcd_out      = bcd_q;
  assign bus.blank_out    = blank_q;
  assign bus.err_out      = err_q;
  assign bus.digit_update = update_q;
  assign bus.frame_valid  = frame_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: reset values, a table of directed
// vectors, randomized scanning against a run-length reference model, and a
// reset-during-filter sequence.
module tb_seg_scan_capture;

  localparam int ND     = 4;
  localparam int STABLE = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  seg_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference patterns, index = digit value, bit0 = a
  logic [6:0] pats [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1100111};

  // Reference model state
  logic [6:0]      m_seg;
  logic [ND-1:0]   m_en;
  int              m_run;
  logic [4*ND-1:0] m_bcd;
  logic [ND-1:0]   m_blank;
  logic [ND-1:0]   m_err;
  logic [ND-1:0]   m_seen;
  logic            m_du;
  logic            m_fv;

  typedef struct {
    logic        ca;
    logic [6:0]  seg;
    logic [3:0]  en;
    int          hold;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
    int          updates;
    int          frames;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seg   = '0;
    m_en    = '0;
    m_run   = 1;
    m_bcd   = '1;
    m_blank = '1;
    m_err   = '0;
    m_seen  = '0;
    m_du    = 1'b0;
    m_fv    = 1'b0;
  endtask

  // A registered sample commits when it has been seen exactly STABLE times in a row
  task automatic model_edge();
    logic [6:0] sn;
    logic [3:0] code;
    int         idx;
    sn   = bus.common_anode ? ~bus.seg_in : bus.seg_in;
    m_du = 1'b0;
    m_fv = 1'b0;
    idx  = 0;
    if (m_run == STABLE && $countones(m_en) == 1) begin
      for (int i = 0; i < ND; i++) if (m_en[i]) idx = i;
      code = 4'hE;
      for (int j = 0; j < 10; j++) if (m_seg == pats[j]) code = 4'(j);
      if (m_seg == 7'b0) code = 4'hF;
      m_bcd[4*idx +: 4] = code;
      m_blank[idx]      = (code == 4'hF);
      m_err[idx]        = (code == 4'hE);
      m_du              = 1'b1;
      m_seen[idx]       = 1'b1;
      if (&m_seen) begin
        m_fv   = 1'b1;
        m_seen = '0;
      end
    end
    if (sn == m_seg && bus.dig_en == m_en) begin
      if (m_run <= STABLE) m_run++;
    end else begin
      m_run = 1;
    end
    m_seg = sn;
    m_en  = bus.dig_en;
  endtask

  task automatic check_output();
    check("bcd_out", 32'(bus.bcd_out), 32'(m_bcd));
    check("blank_out", 32'(bus.blank_out), 32'(m_blank));
    check("err_out", 32'(bus.err_out), 32'(m_err));
    check("digit_update", 32'(bus.digit_update), 32'(m_du));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " bcd_out"}, 32'(bus.bcd_out), 32'h0000FFFF);
    check({tag, " blank_out"}, 32'(bus.blank_out), 32'hF);
    check({tag, " err_out"}, 32'(bus.err_out), 32'h0);
    check({tag, " digit_update"}, 32'(bus.digit_update), 32'h0);
    check({tag, " frame_valid"}, 32'(bus.frame_valid), 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic ca, input logic [6:0] seg, input logic [3:0] en);
    bus.common_anode = ca;
    bus.seg_in       = seg;
    bus.dig_en       = en;
  endtask

  initial begin
    int du_cnt;
    int fv_cnt;
    int first_du;
    int hold;
    int r;
    logic [6:0] seg;
    logic [3:0] en;
    logic       ca;

    vecs[0]  = '{1'b0, 7'b0000110, 4'b0001, 6,  16'hFFF1, 4'hE, 4'h0, 1, 0};
    vecs[1]  = '{1'b0, 7'b1011011, 4'b0010, 6,  16'hFF21, 4'hC, 4'h0, 1, 0};
    vecs[2]  = '{1'b0, 7'b1001111, 4'b0100, 6,  16'hF321, 4'h8, 4'h0, 1, 0};
    vecs[3]  = '{1'b0, 7'b1100110, 4'b1000, 6,  16'h4321, 4'h0, 4'h0, 1, 1};
    vecs[4]  = '{1'b0, 7'b0000111, 4'b0001, 3,  16'h4321, 4'h0, 4'h0, 0, 0};
    vecs[5]  = '{1'b0, 7'b1111111, 4'b0001, 6,  16'h4328, 4'h0, 4'h0, 1, 0};
    vecs[6]  = '{1'b1, 7'b1000000, 4'b0100, 6,  16'h4028, 4'h0, 4'h0, 1, 0};
    vecs[7]  = '{1'b0, 7'b0000001, 4'b0010, 6,  16'h40E8, 4'h0, 4'h2, 1, 0};
    vecs[8]  = '{1'b0, 7'b0000000, 4'b0010, 6,  16'h40F8, 4'h2, 4'h0, 1, 0};
    vecs[9]  = '{1'b0, 7'b0000110, 4'b0011, 10, 16'h40F8, 4'h2, 4'h0, 0, 0};
    vecs[10] = '{1'b0, 7'b1011011, 4'b0000, 10, 16'h40F8, 4'h2, 4'h0, 0, 0};
    vecs[11] = '{1'b0, 7'b1100111, 4'b1000, 6,  16'h90F8, 4'h2, 4'h0, 1, 1};

    apply_stimulus(1'b0, 7'b0, 4'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Directed table: each row is held for its cycle count from the first capture edge
    for (int v = 0; v < 12; v++) begin
      apply_stimulus(vecs[v].ca, vecs[v].seg, vecs[v].en);
      du_cnt   = 0;
      fv_cnt   = 0;
      first_du = -1;
      for (int t = 1; t <= vecs[v].hold; t++) begin
        tick();
        if (bus.digit_update) begin
          du_cnt++;
          if (first_du < 0) first_du = t;
        end
        if (bus.frame_valid) fv_cnt++;
      end
      check($sformatf("vec%0d bcd", v), 32'(bus.bcd_out), 32'(vecs[v].bcd));
      check($sformatf("vec%0d blank", v), 32'(bus.blank_out), 32'(vecs[v].blank));
      check($sformatf("vec%0d err", v), 32'(bus.err_out), 32'(vecs[v].err));
      check($sformatf("vec%0d updates", v), 32'(du_cnt), 32'(vecs[v].updates));
      check($sformatf("vec%0d frames", v), 32'(fv_cnt), 32'(vecs[v].frames));
      if (vecs[v].updates > 0)
        check($sformatf("vec%0d latency", v), 32'(first_du), 32'(STABLE + 1));
    end

    // Randomized scanning with mixed patterns, enables, polarity and hold times
    ca = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) ca = ~ca;
      r = $urandom_range(0, 11);
      if (r < 10)       seg = pats[r];
      else if (r == 10) seg = 7'b0;
      else              seg = 7'($urandom);
      if ($urandom_range(0, 5) == 0) en = 4'($urandom);
      else                           en = 4'(1 << $urandom_range(0, ND - 1));
      apply_stimulus(ca, ca ? ~seg : seg, en);
      hold = $urandom_range(1, 7);
      for (int t = 0; t < hold; t++) tick();
    end

    // Reset in the middle of filtering, then a full re-count after release
    apply_stimulus(1'b0, 7'b0, 4'b0011);
    tick();
    apply_stimulus(1'b0, 7'b1101101, 4'b1000);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("held reset");
    reset = 1'b0;
    for (int t = 1; t <= STABLE + 1; t++) begin
      tick();
      check($sformatf("post-reset pulse t%0d", t), 32'(bus.digit_update),
            32'(t == STABLE + 1));
    end
    check("post-reset slot3", 32'(bus.bcd_out), 32'h00005FFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
